// File: rtl/mem_access_pkg.sv
// Shared types and helpers for the MEM stage: access op codes, FSM states, stall indices.
package mem_access_pkg;

  typedef enum logic [3:0] {
    MemNone = 4'd0,
    MemLb   = 4'd1,
    MemLbu  = 4'd2,
    MemLh   = 4'd3,
    MemLhu  = 4'd4,
    MemLw   = 4'd5,
    MemSb   = 4'd6,
    MemSh   = 4'd7,
    MemSw   = 4'd8
  } mem_op_e;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWait = 2'd1,
    StDone = 2'd2
  } mem_state_e;

  localparam int unsigned STALL_MEM = 4;

  function automatic logic is_load(logic [3:0] op);
    return op inside {MemLb, MemLbu, MemLh, MemLhu, MemLw};
  endfunction

  function automatic logic is_store(logic [3:0] op);
    return op inside {MemSb, MemSh, MemSw};
  endfunction

  function automatic logic is_half(logic [3:0] op);
    return op inside {MemLh, MemLhu, MemSh};
  endfunction

  function automatic logic is_word(logic [3:0] op);
    return op inside {MemLw, MemSw};
  endfunction

endpackage

// File: rtl/mem_access_lane_align.sv
// Combinational byte-lane logic: bus_sel, store-data replication and load extraction/extension.
module mem_lane_align
  import mem_access_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] sdata,
  input  logic [31:0] rdata,
  output logic [3:0]  sel,
  output logic [31:0] wdata,
  output logic [31:0] ldata
);

  logic [7:0]  byte_r;
  logic [15:0] half_r;

  always_comb begin
    byte_r = rdata[7:0];
    unique case (addr_lo)
      2'd0: byte_r = rdata[7:0];
      2'd1: byte_r = rdata[15:8];
      2'd2: byte_r = rdata[23:16];
      2'd3: byte_r = rdata[31:24];
      default: byte_r = rdata[7:0];
    endcase
    half_r = addr_lo[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    sel   = 4'b0000;
    wdata = sdata;
    ldata = 32'h0;
    case (op)
      MemLb:  begin sel = 4'b0001 << addr_lo; ldata = {{24{byte_r[7]}}, byte_r}; end
      MemLbu: begin sel = 4'b0001 << addr_lo; ldata = {24'h0, byte_r}; end
      MemLh:  begin sel = addr_lo[1] ? 4'b1100 : 4'b0011; ldata = {{16{half_r[15]}}, half_r}; end
      MemLhu: begin sel = addr_lo[1] ? 4'b1100 : 4'b0011; ldata = {16'h0, half_r}; end
      MemLw:  begin sel = 4'b1111; ldata = rdata; end
      MemSb:  begin sel = 4'b0001 << addr_lo; wdata = {4{sdata[7:0]}}; end
      MemSh:  begin sel = addr_lo[1] ? 4'b1100 : 4'b0011; wdata = {2{sdata[15:0]}}; end
      MemSw:  sel = 4'b1111;
      default: sel = 4'b0000;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// MEM pipeline stage: result pass-through plus req/ack load/store with a bus watchdog.
// Optional misaligned-access exceptions are enabled by defining MEM_ALIGN_EXC_EN.
module mem_access
  import mem_access_pkg::*;
#(
  parameter int unsigned BUS_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall,
  input  logic [4:0]  mem_wd,
  input  logic [31:0] mem_wdata,
  input  logic        mem_wreg,
  input  logic        mem_whilo,
  input  logic [31:0] mem_hi,
  input  logic [31:0] mem_lo,
  input  logic [3:0]  mem_op,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_sdata,
  output logic [4:0]  wb_wd,
  output logic [31:0] wb_wdata,
  output logic        wb_wreg,
  output logic        wb_whilo,
  output logic [31:0] wb_hi,
  output logic [31:0] wb_lo,
  output logic        stallreq,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_sel,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
`ifdef MEM_ALIGN_EXC_EN
  output logic        excp_adel,
  output logic        excp_ades,
`endif
  output logic        bus_err
);

  localparam logic [9:0] TimeoutLast = 10'(BUS_TIMEOUT - 1);

  mem_state_e  state_q, state_d;
  logic [31:0] ld_buf_q, ld_buf_d;
  logic [9:0]  cnt_q, cnt_d;
  logic        bus_err_q, bus_err_d;
  logic        req, stl, misalign, is_acc;
  logic [3:0]  sel;
  logic [31:0] ldata, ld_src;
  logic        unused_stall;

  assign unused_stall = ^{stall[5], stall[3:0]};

`ifdef MEM_ALIGN_EXC_EN
  assign misalign = (is_half(mem_op) & mem_addr[0]) | (is_word(mem_op) & (mem_addr[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  assign is_acc = (is_load(mem_op) | is_store(mem_op)) & ~misalign;

  always_comb begin
    state_d   = state_q;
    ld_buf_d  = ld_buf_q;
    cnt_d     = cnt_q;
    bus_err_d = 1'b0;
    req       = 1'b0;
    stl       = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (is_acc) begin
          req   = 1'b1;
          cnt_d = 10'd0;
          if (bus_ack) begin
            ld_buf_d = bus_rdata;
            state_d  = StDone;
          end else begin
            stl     = 1'b1;
            state_d = StWait;
          end
        end
      end
      StWait: begin
        req = 1'b1;
        stl = 1'b1;
        if (bus_ack) begin
          ld_buf_d = bus_rdata;
          cnt_d    = 10'd0;
          state_d  = StDone;
        end else if (cnt_q == TimeoutLast) begin
          // Watchdog abort: the load result reads as zero.
          ld_buf_d  = 32'h0;
          cnt_d     = 10'd0;
          bus_err_d = 1'b1;
          state_d   = StDone;
        end else begin
          cnt_d = cnt_q + 10'd1;
        end
      end
      StDone: begin
        if (!stall[STALL_MEM]) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      ld_buf_q  <= 32'h0;
      cnt_q     <= 10'd0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ld_buf_q  <= ld_buf_d;
      cnt_q     <= cnt_d;
      bus_err_q <= bus_err_d;
    end
  end

  // Zero-wait completion reads the bus directly; afterwards the buffered word is used.
  assign ld_src = (state_q == StDone) ? ld_buf_q : bus_rdata;

  mem_lane_align u_lane (
    .op      (mem_op),
    .addr_lo (mem_addr[1:0]),
    .sdata   (mem_sdata),
    .rdata   (ld_src),
    .sel     (sel),
    .wdata   (bus_wdata),
    .ldata   (ldata)
  );

  // Gating with rst makes the request drop asynchronously when reset hits mid-access.
  assign bus_req  = rst & req;
  assign stallreq = rst & stl;
  assign bus_we   = rst & req & is_store(mem_op);
  assign bus_sel  = bus_req ? sel : 4'b0000;
  assign bus_addr = {mem_addr[31:2], 2'b00};
  assign bus_err  = bus_err_q;

  assign wb_wd    = mem_wd;
  assign wb_wdata = is_load(mem_op) ? ldata : mem_wdata;
  assign wb_whilo = mem_whilo;
  assign wb_hi    = mem_hi;
  assign wb_lo    = mem_lo;

`ifdef MEM_ALIGN_EXC_EN
  assign wb_wreg   = mem_wreg & ~misalign;
  assign excp_adel = rst & misalign & is_load(mem_op);
  assign excp_ades = rst & misalign & is_store(mem_op);
`else
  assign wb_wreg = mem_wreg;
`endif

endmodule
